// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the parameterised register file.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/reg_file_clear_ctrl.sv
// Bulk-clear sequencer: walks every entry once, one per enabled cycle, and
// reports busy while it owns the array write port.
module reg_file_clear_ctrl
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clear,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en && clear)     state_nxt = CLEAR;
      CLEAR:   if (en && cnt == '1) state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Counter sits at 0 in IDLE and wraps back to 0 on the last cleared entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (en) begin
      if (state == CLEAR) cnt <= cnt + 1'b1;
      else                cnt <= '0;
    end
  end

  always_comb begin
    busy     = (state == CLEAR);
    clr_we   = (state == CLEAR) && en;
    clr_addr = cnt;
  end

endmodule

// File: rtl/reg_file_param.sv
// Two-read, one-write register file with registered reads, optional bypass,
// optional hardwired-zero entry 0 and a multi-cycle bulk clear.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic              readEn,
  input  logic              writeEn,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              clear,
  output logic [DATA_W-1:0] readOut1,
  output logic [DATA_W-1:0] readOut2,
  output logic              readValid,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NRD   = 2;

  logic [DATA_W-1:0]           rf [DEPTH];
  logic                        clr_we;
  logic [ADDR_W-1:0]           clr_addr;
  logic                        idle_go, wr_ok, rd_ok;
  logic [NRD-1:0][ADDR_W-1:0]  rs;
  logic [NRD-1:0][DATA_W-1:0]  rdata;

  reg_file_clear_ctrl #(.ADDR_W(ADDR_W)) u_clr (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clear    (clear),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A clear request takes the whole cycle: any read/write beside it is dropped.
  assign idle_go = en && !busy && !clear;
  assign wr_ok   = idle_go && writeEn && !(ZERO_REG && rd == '0);
  assign rd_ok   = idle_go && readEn;
  assign rs      = {rs2, rs1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (clr_we) begin
      rf[clr_addr] <= '0;
    end else if (wr_ok) begin
      rf[rd] <= dataIn;
    end
  end

  // Zero-register masking is applied last so it also wins over the bypass.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rdata[p] = rf[rs[p]];
      if (BYPASS && wr_ok && rd == rs[p]) rdata[p] = dataIn;
      if (ZERO_REG && rs[p] == '0)        rdata[p] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readOut1  <= '0;
      readOut2  <= '0;
      readValid <= 1'b0;
    end else if (en) begin
      if (rd_ok) begin
        readOut1  <= rdata[0];
        readOut2  <= rdata[1];
        readValid <= 1'b1;
      end else begin
        readValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench: two instances (bypass+zero-reg, and neither) share stimulus;
// read expectations go through a scoreboard queue and are checked on return.
module tb_reg_file_param;

  logic        clk = 1'b0, reset = 1'b0, en = 1'b0;
  logic        readEn = 1'b0, writeEn = 1'b0, clear = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic [31:0] dataIn = '0;

  logic [31:0] a_o1, a_o2, b_o1, b_o2;
  logic        a_v, a_busy, b_v, b_busy;

  always #5 clk = ~clk;

  reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
    .clk(clk), .reset(reset), .en(en), .rs1(rs1), .rs2(rs2), .rd(rd),
    .readEn(readEn), .writeEn(writeEn), .dataIn(dataIn), .clear(clear),
    .readOut1(a_o1), .readOut2(a_o2), .readValid(a_v), .busy(a_busy));

  reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .clk(clk), .reset(reset), .en(en), .rs1(rs1), .rs2(rs2), .rd(rd),
    .readEn(readEn), .writeEn(writeEn), .dataIn(dataIn), .clear(clear),
    .readOut1(b_o1), .readOut2(b_o2), .readValid(b_v), .busy(b_busy));

  typedef struct {
    logic [31:0] a1, a2, b1, b2;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] ma [32];
  logic [31:0] mb [32];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_a(input logic [4:0] r, input bit we,
                                        input logic [4:0] wa, input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (we && wa == r) return wd;
    return ma[r];
  endfunction

  task automatic zero_models();
    for (int i = 0; i < 32; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
  endtask

  // One idle cycle of optional write and optional read; checks the read result.
  task automatic rw(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                    input bit re, input logic [4:0] r1, input logic [4:0] r2,
                    input string tag);
    exp_t e;
    writeEn = we; rd = wa; dataIn = wd;
    readEn  = re; rs1 = r1; rs2 = r2;
    if (re) begin
      e.a1 = exp_a(r1, we, wa, wd);
      e.a2 = exp_a(r2, we, wa, wd);
      e.b1 = mb[r1];
      e.b2 = mb[r2];
      sb.push_back(e);
    end
    if (we) begin
      if (wa != 5'd0) ma[wa] = wd;
      mb[wa] = wd;
    end
    tick();
    writeEn = 1'b0;
    readEn  = 1'b0;
    if (re) begin
      e = sb.pop_front();
      chk({tag, ".a1"}, a_o1, e.a1);
      chk({tag, ".a2"}, a_o2, e.a2);
      chk({tag, ".b1"}, b_o1, e.b1);
      chk({tag, ".b2"}, b_o2, e.b2);
      chk({tag, ".va"}, 32'(a_v), 32'd1);
      chk({tag, ".vb"}, 32'(b_v), 32'd1);
    end
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 32; i += 2) rw(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 5'(i + 1), tag);
  endtask

  initial begin
    int nb;
    zero_models();

    // Reset state, observed while reset is held
    #12;
    chk("rst_o1", a_o1, 32'd0);
    chk("rst_o2", b_o2, 32'd0);
    chk("rst_v", 32'(a_v | b_v), 32'd0);
    chk("rst_busy", 32'(a_busy | b_busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    en    = 1'b1;

    // Basic write then read, valid pulse
    rw(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, "wr5");
    rw(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, "rd5");
    tick();
    chk("valid_pulse", 32'(a_v | b_v), 32'd0);
    chk("hold_o1", a_o1, 32'hDEADBEEF);

    // Freeze: en=0 holds outputs/valid and drops the write
    rw(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, "rd5b");
    en = 1'b0; writeEn = 1'b1; rd = 5'd6; dataIn = 32'h66; readEn = 1'b1; rs1 = 5'd6;
    tick();
    chk("frz_valid", 32'(a_v), 32'd1);
    chk("frz_o1", a_o1, 32'hDEADBEEF);
    en = 1'b1; writeEn = 1'b0; readEn = 1'b0;
    rw(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd5, "frz_rd6");

    // Same-cycle collision: bypass vs. old value
    rw(1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 5'd7, "coll7");
    rw(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, "reread7");

    // Register 0 behaviour, including a colliding write to 0
    rw(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, "wr0");
    rw(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd5, "rd0");
    rw(1'b1, 5'd0, 32'hA5A5A5A5, 1'b1, 5'd0, 5'd0, "coll0");

    // Fill with index, then bulk clear with traffic during it
    for (int i = 0; i < 32; i++) rw(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 5'd0, "fill");
    rw(1'b0, 5'd0, 32'd0, 1'b1, 5'd30, 5'd31, "fill_rd");
    clear = 1'b1; writeEn = 1'b1; rd = 5'd4; dataIn = 32'h44; readEn = 1'b1; rs1 = 5'd4;
    tick();
    clear = 1'b0; writeEn = 1'b0; readEn = 1'b0;
    chk("clr_start_v", 32'(a_v | b_v), 32'd0);
    chk("clr_hold_o1", a_o1, 32'd30);
    nb = 0;
    for (int k = 0; k < 100 && a_busy; k++) begin
      nb++;
      if (k == 21) chk("clr_mid_v", 32'(a_v | b_v), 32'd0);
      writeEn = (k == 20); readEn = (k == 20); clear = (k == 25);
      rd = 5'd3; dataIn = 32'hBAD; rs1 = 5'd31;
      tick();
    end
    writeEn = 1'b0; readEn = 1'b0; clear = 1'b0;
    chk("busy_len", 32'(nb), 32'd32);
    chk("busy_b_done", 32'(b_busy), 32'd0);
    chk("clr_end_o2", a_o2, 32'd31);
    zero_models();
    read_all("after_clr");

    // Clear paused by en=0 at counter 12
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (12) tick();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("pause_busy", 32'(a_busy & b_busy), 32'd1);
    end
    en = 1'b1;
    nb = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      nb++;
      if (!a_busy) break;
    end
    chk("resume_len", 32'(nb), 32'd20);

    // Reset mid-clear at counter 8
    rw(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd0, "wr9");
    rw(1'b1, 5'd20, 32'h2020, 1'b0, 5'd0, 5'd0, "wr20");
    rw(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd20, "rd9_20");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (8) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", 32'(a_busy | b_busy), 32'd0);
    chk("arst_o1", a_o1, 32'd0);
    chk("arst_o2", b_o2, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    zero_models();
    tick();
    chk("post_rst_idle", 32'(a_busy | b_busy), 32'd0);
    rw(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd20, "post_rst_rd");
    read_all("post_rst_all");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the existing 32x32 register file, generalised in data width and depth.
- Adds:
  - simultaneous read and write in the same cycle
  - optional write-to-read bypass
  - optional hardwired-zero register 0
  - multi-cycle bulk-clear sequencer with a busy flag
- Sits between the decode stage (supplies rs1/rs2/rd) and the writeback stage (supplies dataIn/writeEn).
- Read data is registered: one cycle of latency.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, address width. DEPTH = 2**ADDR_W entries, so no address can be out of range.
- ZERO_REG, 1: when 1, entry 0 always reads 0 and writes to it are discarded. When 0, entry 0 is an ordinary register.
- BYPASS, 1: when 1, a same-cycle write to a register being read is forwarded to the read output. When 0, the read returns the pre-write value.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  block enable. When 0, no state changes.
- rs1  in  ADDR_W  read address, port 1.
- rs2  in  ADDR_W  read address, port 2.
- rd  in  ADDR_W  write address.
- readEn  in  1  read request.
- writeEn  in  1  write request.
- dataIn  in  DATA_W  write data.
- clear  in  1  start bulk clear (single-cycle pulse, sampled at clk).
- readOut1  out  DATA_W  registered read data, port 1.
- readOut2  out  DATA_W  registered read data, port 2.
- readValid  out  1  high for one cycle when readOut1/readOut2 carry new data.
- busy  out  1  high while the clear sequence runs.

Behaviour:
- **Reset:** One clock (clk) with asynchronous, active-low reset (reset). While reset=0:
  - all DEPTH entries are 0
  - readOut1 = readOut2 = 0, readValid = 0, busy = 0
  - FSM is in IDLE and the clear counter is 0
  - Reset asserted mid-clear aborts the clear immediately; the array is zeroed anyway.
- **Enable:** en=0 means a full freeze at the edge: array, outputs, readValid, FSM and counter all hold. A clear in progress pauses and resumes when en returns to 1.
- **Idle reads** (state IDLE, en=1, clear=0), with readEn=1:
  - readOut1 <= rf[rs1] and readOut2 <= rf[rs2] at the next edge.
  - readValid <= 1 at that same edge.
  - With readEn=0: readValid <= 0 and readOut1/readOut2 hold their last values.
- **Idle writes:** writeEn=1 writes rf[rd] <= dataIn at the edge.
  - readEn and writeEn are independent; both may be served in the same cycle. There is no read-over-write priority.
- **Same-cycle collision** (writeEn=1, readEn=1, rd==rsX, not a discarded zero-reg write):
  - BYPASS=1: readOutX <= dataIn.
  - BYPASS=0: readOutX <= old rf[rsX].
- **ZERO_REG=1:**
  - A write with rd=0 is discarded.
  - Reads of address 0 return 0, including under bypass.
- **Clear FSM**, states IDLE and CLEAR:
  - IDLE, en=1, clear=1: go to CLEAR, counter <= 0, busy <= 1. Any writeEn/readEn in that cycle is dropped and readValid <= 0.
  - CLEAR, en=1: rf[counter] <= 0, counter <= counter+1.
  - On the edge that clears entry DEPTH-1: go to IDLE, busy <= 0, counter <= 0.
  - Total duration is DEPTH enabled cycles with busy=1.
  - In CLEAR, clear, writeEn and readEn are ignored; readValid stays 0 and readOut1/readOut2 hold.
- **Arithmetic:** counter is ADDR_W bits and wraps naturally at the end of a clear; no extra terminal state is needed.

Decomposition:
- Package reg_file_pkg holds:
  - state enum {IDLE, CLEAR}
  - default constants: DATA_W=32, ADDR_W=5
- Sub-module reg_file_clear_ctrl holds the FSM, counter and busy logic.
  - Inputs: clk, reset, en, clear.
  - Outputs: busy, clr_we, clr_addr.
  - The top level muxes the clear write into the array write port.

Test Plan:
1. Reset low, then release. Write rd=5 dataIn=0xDEADBEEF. Next cycle readEn with rs1=5, rs2=0 -> after 1 cycle readOut1=0xDEADBEEF, readOut2=0, readValid pulses for 1 cycle.
2. Same-cycle write rd=7 dataIn=0x12345678 with readEn rs1=7, rs2=7:
   - BYPASS=1 -> both outputs 0x12345678.
   - BYPASS=0 -> both 0, then a re-read returns 0x12345678.
3. ZERO_REG=1: write rd=0 dataIn=0xFFFFFFFF, then read rs1=0 -> 0. ZERO_REG=0, same sequence -> 0xFFFFFFFF.
4. Fill all 32 entries with their index. Pulse clear -> busy=1 for exactly 32 cycles.
   - writeEn issued mid-clear has no effect.
   - After busy falls, every entry reads 0.
5. Start a clear, hold en=0 for 10 cycles at counter=12 -> busy stays 1 and the counter holds. After en returns, busy falls 20 cycles later.
6. Assert reset mid-clear at counter=8 -> busy=0 and readOut1/readOut2=0 immediately (asynchronously). After release, all entries read 0 and the FSM is IDLE.
